// File: rtl/cs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cs_pkg
//  Description : Shared constants and a helper for the CS result buffer
//                slice. Widths and depths here are the defaults picked up by
//                the interface, the FIFO and the buffer top.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cs_pkg;

    localparam int CS_DW        = 10;                    // CS result width
    localparam int CS_XW        = 8;                     // CS sample width
    localparam int CS_WARMUP    = 9;                     // CS window length
    localparam int CS_BUF_DEPTH = 8;                     // FIFO entries
    localparam int CS_BUF_AW    = $clog2(CS_BUF_DEPTH);  // FIFO address bits
    localparam int CS_CW        = 8;                     // drop counter width

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CS_CW-1:0] sat_inc(input logic [CS_CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cs_result_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cs_result_buffer_if
//  Description : Bundles the CS-side inputs and the host-side drain handshake
//                of the result buffer.
//  Ports       : in_en, Y_in            CS side (driven by master)
//                out_ready              host accept (driven by master)
//                out_data, out_valid    head of FIFO (driven by slave)
//                level, drop_cnt,
//                overflow               status (driven by slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cs_result_buffer_if
    import cs_pkg::*;
#(
    parameter int DW = CS_DW,
    parameter int AW = CS_BUF_AW,
    parameter int CW = CS_CW
) ();

    logic          in_en;
    logic [DW-1:0] Y_in;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic [CW-1:0] drop_cnt;
    logic          overflow;

    modport master (
        output in_en, Y_in, out_ready,
        input  out_data, out_valid, level, drop_cnt, overflow
    );

    modport slave (
        input  in_en, Y_in, out_ready,
        output out_data, out_valid, level, drop_cnt, overflow
    );

endinterface
`default_nettype wire

// File: rtl/cs_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cs_sync_fifo
//  Description : Generic single-clock FIFO, 2**AW entries, with wrap-bit
//                pointers. Read data is a combinational view of the head
//                entry and reads as zero while empty. Push while full is
//                legal when a pop happens on the same edge.
//  Ports       : clk, reset          clock, async active-high reset
//                push, wdata         write strobe and data
//                pop                 read strobe (caller guarantees !empty)
//                full, empty, level  occupancy status
//                rdata               head entry, 0 when empty
//  Revision    : 1.0 - initial release
// ============================================================================
module cs_sync_fifo #(
    parameter int DW = 10,
    parameter int AW = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire logic [DW-1:0] wdata,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        level,
    output logic [DW-1:0]      rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Storage has no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Same index, different wrap bit means the writer is a whole lap ahead.
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign empty = (wr_ptr == rd_ptr);
    // Modular pointer difference is the occupancy, 0..DEPTH.
    assign level = wr_ptr - rd_ptr;
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/cs_result_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cs_result_buffer
//  Description : Downstream stage of the CS system. Tracks how many
//                consecutive valid X samples have entered the CS window and
//                captures Y only when the window is fully valid. Captured
//                results are queued in a FIFO and drained over valid/ready;
//                captures that find the FIFO full (with no pop on the same
//                edge) are counted and flagged.
//  Ports       : clk    rising-edge clock shared with CS
//                reset  asynchronous active-high reset
//                bus    cs_result_buffer_if.slave (in_en, Y_in, out_ready in;
//                       out_data, out_valid, level, drop_cnt, overflow out)
//  Revision    : 1.0 - initial release
// ============================================================================
module cs_result_buffer
    import cs_pkg::*;
#(
    parameter int WARMUP = CS_WARMUP,
    parameter int DEPTH  = CS_BUF_DEPTH,
    parameter int AW     = $clog2(DEPTH),
    parameter int DW     = CS_DW,
    parameter int CW     = CS_CW
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cs_result_buffer_if.slave   bus
);

    localparam int WCW = $clog2(WARMUP + 1);
    localparam logic [WCW-1:0] WARMUP_VAL = WCW'(WARMUP);

    logic [WCW-1:0] wcnt;
    logic [CW-1:0]  drop_cnt;
    logic           overflow;

    logic           cap;
    logic           push;
    logic           pop;
    logic           drop;
    logic           full;
    logic           empty;
    logic [AW:0]    level;
    logic [DW-1:0]  rdata;

    // Y is meaningful once the whole window holds valid samples; wcnt is the
    // pre-edge value, so this edge's in_en only matters for later captures.
    assign cap  = (wcnt == WARMUP_VAL);
    assign pop  = !empty && bus.out_ready;
    // A pop on the same edge frees the slot the capture needs.
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt     <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (!bus.in_en) begin
                wcnt <= '0;
            end else if (wcnt != WARMUP_VAL) begin
                wcnt <= wcnt + 1'b1;
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end

    cs_sync_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.Y_in),
        .full  (full),
        .empty (empty),
        .level (level),
        .rdata (rdata)
    );

    assign bus.out_data  = rdata;
    assign bus.out_valid = !empty;
    assign bus.level     = level;
    assign bus.drop_cnt  = drop_cnt;
    assign bus.overflow  = overflow;

endmodule
`default_nettype wire

// File: tb/tb_cs_result_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cs_result_buffer
//  Description : Self-checking bench for cs_result_buffer. The driver keeps a
//                small behavioural model of warm-up, occupancy and drops and
//                pushes every expected capture into a queue; a monitor on the
//                falling edge compares status and pops/compares drained data.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cs_result_buffer;
    import cs_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cs_result_buffer_if bus ();

    cs_result_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    int exp_q[$];
    int m_wcnt;
    int m_level;
    int m_drop;
    int m_ovf;
    int dut_max;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_wcnt  = 0;
        m_level = 0;
        m_drop  = 0;
        m_ovf   = 0;
        dut_max = 0;
    endtask

    // Drive one edge and advance the model; returns at posedge+1.
    task automatic step(input bit en, input bit rdy, input int y);
        bit cap, pop, full;
        bus.in_en     = en;
        bus.out_ready = rdy;
        bus.Y_in      = 10'(y);
        cap  = (m_wcnt == 9);
        pop  = (m_level != 0) && rdy;
        full = (m_level == 8);
        @(posedge clk);
        if (cap && (!full || pop)) exp_q.push_back(y);
        if (cap && full && !pop) begin
            if (m_drop != 255) m_drop++;
            m_ovf = 1;
        end
        if ((cap && (!full || pop)) && !pop) m_level++;
        else if (!(cap && (!full || pop)) && pop) m_level--;
        m_wcnt = en ? ((m_wcnt == 9) ? 9 : m_wcnt + 1) : 0;
        #1;
    endtask

    task automatic do_reset();
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        bus.Y_in      = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 model_clear();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Monitor: status every cycle, data compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            chk("level",     int'(bus.level),     m_level);
            chk("out_valid", int'(bus.out_valid), int'(m_level != 0));
            chk("drop_cnt",  int'(bus.drop_cnt),  m_drop);
            chk("overflow",  int'(bus.overflow),  m_ovf);
            if (int'(bus.level) > dut_max) dut_max = int'(bus.level);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", exp_q.size(), 1);
                end else begin
                    chk("out_data", int'(bus.out_data), exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("out_data_empty", int'(bus.out_data), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        bit gapped;
        bit en;
        int y;

        reset         = 1'b1;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        bus.Y_in      = '0;
        model_clear();
        #1;
        chk("reset_level",    int'(bus.level),     0);
        chk("reset_valid",    int'(bus.out_valid), 0);
        chk("reset_data",     int'(bus.out_data),  0);
        chk("reset_drop",     int'(bus.drop_cnt),  0);
        chk("reset_overflow", int'(bus.overflow),  0);
        do_reset();

        // 1: continuous valid, first capture at edge 10.
        for (int e = 1; e <= 11; e++) begin
            step(1'b1, 1'b1, 11);
            if (e == 9)  chk("t1_level_e9",  int'(bus.level), 0);
            if (e == 10) chk("t1_level_e10", int'(bus.level), 1);
            if (e == 11) begin
                chk("t1_level_e11", int'(bus.level),     1);
                chk("t1_valid_e11", int'(bus.out_valid), 1);
                chk("t1_data_e11",  int'(bus.out_data),  11);
            end
        end

        // 2: a gap at edge 5 restarts warm-up; capture at edge 15.
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            step(e != 5, 1'b0, e + 100);
            if (e == 14) chk("t2_level_e14", int'(bus.level), 0);
            if (e == 15) begin
                chk("t2_level_e15", int'(bus.level),    1);
                chk("t2_data_e15",  int'(bus.out_data), 115);
            end
        end

        // 3: ten captures into a stalled FIFO.
        do_reset();
        for (int e = 1; e <= 9; e++) step(1'b1, 1'b0, 0);
        for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, k);
        chk("t3_level",    int'(bus.level),    8);
        chk("t3_data",     int'(bus.out_data), 1);
        chk("t3_drop",     int'(bus.drop_cnt), 2);
        chk("t3_overflow", int'(bus.overflow), 1);

        // 4: full, pop and capture on the same edge.
        step(1'b1, 1'b1, 99);
        chk("t4_level", int'(bus.level),    8);
        chk("t4_head",  int'(bus.out_data), 2);
        chk("t4_drop",  int'(bus.drop_cnt), 2);
        for (int i = 0; i < 20 && m_level != 0; i++) step(1'b0, 1'b1, 0);
        @(negedge clk);
        chk("t4_drained", exp_q.size(), 0);

        // 5: twenty captures across pointer wrap, out_ready toggling.
        do_reset();
        v = 0;
        gapped = 1'b0;
        for (int e = 0; e < 200 && v < 20; e++) begin
            en = 1'b1;
            if (v == 10 && !gapped) begin
                en = 1'b0;
                gapped = 1'b1;
            end
            y = 0;
            if (m_wcnt == 9) begin
                y = v;
                v++;
            end
            step(en, (e % 2) == 0, y);
        end
        for (int i = 0; i < 40 && m_level != 0; i++) step(1'b0, 1'b1, 0);
        @(negedge clk);
        chk("t5_drained",   exp_q.size(),        0);
        chk("t5_level",     int'(bus.level),     0);
        chk("t5_no_drop",   int'(bus.drop_cnt),  0);
        chk("t5_max_level", int'(dut_max <= 8),  1);

        // 6: reset in the middle of operation.
        do_reset();
        for (int e = 1; e <= 9; e++) step(1'b1, 1'b0, 0);
        for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, k);
        for (int i = 0; i < 10 && m_level != 5; i++) step(1'b0, 1'b1, 0);
        chk("t6_pre_level",    int'(bus.level),    5);
        chk("t6_pre_overflow", int'(bus.overflow), 1);
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid",    int'(bus.out_valid), 0);
        chk("t6_level",    int'(bus.level),     0);
        chk("t6_drop",     int'(bus.drop_cnt),  0);
        chk("t6_overflow", int'(bus.overflow),  0);
        chk("t6_data",     int'(bus.out_data),  0);
        model_clear();
        @(negedge clk);
        #2 reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0, 7);
            if (e == 9) chk("t6_level_e9", int'(bus.level), 0);
            if (e == 10) begin
                chk("t6_level_e10", int'(bus.level),    1);
                chk("t6_data_e10",  int'(bus.out_data), 7);
            end
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
